alu_bus_arbiter8: RTL and testbench
===================================

// Module: alu_bus_arbiter8
// PURPOSE
//   Round-robin arbiter and sequencer that shares the 8:1 32-bit result mux (mux8x3_32b) among
//   8 requesters. Picks a winner, drives the mux select, captures the mux output into a hold
//   register and presents it downstream with a valid/ready handshake.
//   Sits between the ALU-side producers and the shared 32-bit result bus.
// PARAMETERS
//   WIDTH     32      data width of mux_out / out_data
//   PARK_SEL  3'b000  mux_sel value driven while idle
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst_n      in   1      synchronous reset, active low
//   req        in   8      req[i]=1: requester i has data on its mux input
//   gnt        out  8      one-hot, one-cycle pulse: requester i's data captured
//   mux_sel    out  3      select to mux8x3_32b; registered
//   mux_out    in   WIDTH  combinational output of mux8x3_32b
//   out_valid  out  1      out_data/out_src valid
//   out_ready  in   1      downstream accepts when out_valid & out_ready
//   out_data   out  WIDTH  captured word
//   out_src    out  3      index of requester that produced out_data
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Clocking and reset
//   - One clock. Reset is synchronous, active low: rst_n sampled low at a rising edge gives
//     state=IDLE, ptr=0, gnt=0, out_valid=0, out_data=0, out_src=0, mux_sel=PARK_SEL, busy=0.
//   - A reset mid-transfer in SAMPLE or HOLD aborts the transfer. No gnt is issued for it.
//   Select encoding
//   - Requester i is wired to the mux input whose select code is 7-i:
//     req[0] on input a (sel 3'b111), req[7] on input h (sel 3'b000).
//   State machine (IDLE -> SAMPLE -> HOLD -> IDLE)
//   - IDLE: mux_sel=PARK_SEL.
//       If req!=0, winner = first set bit scanning ptr, ptr+1, ... mod 8.
//       Register winner, mux_sel<=7-winner, go to SAMPLE. Otherwise stay in IDLE.
//   - SAMPLE: mux_sel holds 7-winner. At the edge:
//       out_data<=mux_out, out_src<=winner, out_valid<=1;
//       gnt<=1<<winner for exactly one cycle;
//       ptr<=winner+1 (7 wraps to 0); go to HOLD.
//       The capture proceeds even if req[winner] dropped during SAMPLE.
//   - HOLD: mux_sel returns to PARK_SEL. out_valid=1; out_data and out_src stay stable.
//       On out_valid&out_ready: out_valid<=0, go to IDLE.
//       New requests are not evaluated while in HOLD.
//   Timing
//   - Latency: req first sampled high in IDLE -> out_valid high 2 edges later.
//   - Maximum throughput is one word per 3 cycles, with out_ready held 1.
//   Requester protocol
//   - Hold req and data stable until gnt. Deassert req the cycle after gnt.
//   - A req still high after gnt counts as a new request.
//   Fairness and arbitration details
//   - A requester that just won has lowest priority in the next arbitration.
//   - Simultaneous requests are resolved only by ptr. No starvation: worst-case wait is 7 transfers.
//   - gnt is never asserted for more than one cycle per transfer, and never while rst_n=0.
// TESTING
//   1 Reset: rst_n=0 for 2 edges with req=8'hFF
//     -> out_valid=0, gnt=0, mux_sel=3'b000, out_data=0, busy=0.
//   2 Single: req=8'h01, requester 0 drives 32'hFFFFFFFF, out_ready=1
//     -> mux_sel=3'b111 in SAMPLE; out_valid after 2 edges;
//        out_data=32'hFFFFFFFF, out_src=0, gnt=8'h01 for one cycle.
//   3 Round robin: req=8'hFF held, data_i=32'h10000000+i, out_ready=1
//     -> winners 0,1,...,7,0; mux_sel 111,110,...,000,111; out_data tracks winner.
//   4 Backpressure: requester 3 drives 32'h12345678, out_ready=0 for 5 cycles in HOLD, req=8'hFF
//     -> out_data=32'h12345678 stable; no new gnt;
//        out_ready=1 -> out_valid drops next edge, then requester 4 is granted.
//   5 Wrap: after winner 7, req=8'h81
//     -> next winner 0 (mux_sel 3'b111), then 7 (mux_sel 3'b000).
//   6 Reset mid-HOLD: assert rst_n=0 while out_valid=1
//     -> out_valid=0 next edge, ptr=0; after release, req=8'h06 grants requester 1 first.

Source files
------------

// File: rtl/alu_bus_arbiter8_if.sv
// Bus bundle between the result-bus arbiter and its surroundings:
// the requesters and the shared 8:1 mux on one side, the downstream consumer on the other.
interface alu_bus_arbiter8_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       req;
    logic [7:0]       gnt;
    logic [2:0]       mux_sel;
    logic [WIDTH-1:0] mux_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_src;
    logic             busy;

    // Arbiter side
    modport master (
        input  req,
        input  mux_out,
        input  out_ready,
        output gnt,
        output mux_sel,
        output out_valid,
        output out_data,
        output out_src,
        output busy
    );

    // Requesters, mux and downstream consumer side
    modport slave (
        output req,
        output mux_out,
        output out_ready,
        input  gnt,
        input  mux_sel,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  busy
    );
endinterface

// File: rtl/alu_bus_arbiter8.sv
// Round-robin arbiter and sequencer for the shared 8:1 32-bit result mux.
// One transfer walks IDLE -> SAMPLE -> HOLD -> IDLE: pick a winner, steer the
// mux to it for one cycle, capture the mux output, then hold it on the
// valid/ready output until the consumer takes it.
module alu_bus_arbiter8 #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] PARK_SEL = 3'b000
) (
    input logic               clk,
    input logic               rst_n,
    alu_bus_arbiter8_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       winner, winner_n;
    logic [2:0]       mux_sel, mux_sel_n;
    logic [7:0]       gnt, gnt_n;
    logic             out_valid, out_valid_n;
    logic [WIDTH-1:0] out_data, out_data_n;
    logic [2:0]       out_src, out_src_n;
    logic [3:0]       pick;

    // Round-robin search: first set bit of r scanning from p upwards, mod 8.
    // Result is {found, index}. Scanning offsets from high to low lets the
    // smallest offset overwrite, so the first requester after p wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Requester i sits on mux input 7-i (req[0] on input a, req[7] on input h).
    function automatic logic [2:0] sel_of(input logic [2:0] idx);
        return 3'd7 - idx;
    endfunction

    assign pick = rr_pick(bus.req, ptr);

    // Next-state and next-register values; every register holds unless a state acts on it.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        winner_n    = winner;
        mux_sel_n   = mux_sel;
        gnt_n       = 8'h00;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_src_n   = out_src;

        unique case (state)
            IDLE: begin
                mux_sel_n = PARK_SEL;
                if (pick[3]) begin
                    winner_n  = pick[2:0];
                    mux_sel_n = sel_of(pick[2:0]);
                    state_n   = SAMPLE;
                end
            end
            SAMPLE: begin
                // Capture unconditionally: a requester dropping req here still gets its word taken.
                out_data_n  = bus.mux_out;
                out_src_n   = winner;
                out_valid_n = 1'b1;
                gnt_n       = 8'h01 << winner;
                ptr_n       = winner + 3'd1;
                mux_sel_n   = PARK_SEL;
                state_n     = HOLD;
            end
            HOLD: begin
                // Requests are not re-evaluated until the held word is accepted.
                mux_sel_n = PARK_SEL;
                if (out_valid && bus.out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                mux_sel_n   = PARK_SEL;
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            winner    <= 3'd0;
            mux_sel   <= PARK_SEL;
            gnt       <= 8'h00;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 3'd0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            winner    <= winner_n;
            mux_sel   <= mux_sel_n;
            gnt       <= gnt_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_src   <= out_src_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.mux_sel   = mux_sel;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_src   = out_src;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_bus_arbiter8.sv
// Bench for alu_bus_arbiter8: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_bus_arbiter8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] data_tab [8];

    alu_bus_arbiter8_if #(.WIDTH(32)) bus ();

    alu_bus_arbiter8 #(.WIDTH(32), .PARK_SEL(3'b000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Shared mux: select code s carries requester 7-s.
    assign bus.mux_out = data_tab[3'd7 - bus.mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // age: 0 idle, 1 mux steered to winner, >=2 word held on the output.
    int          m_age;
    int          m_win;
    int          m_ptr;
    bit          m_valid;
    bit          m_init;
    logic [31:0] m_data;
    logic [2:0]  m_src;
    logic [7:0]  m_gnt;

    initial begin
        m_init = 1'b0;
    end

    always @(posedge clk) begin
        int w;
        if (!rst_n) begin
            m_age   <= 0;
            m_win   <= 0;
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_src   <= 3'd0;
            m_gnt   <= 8'h00;
            m_init  <= 1'b1;
        end else if (m_init) begin
            m_gnt <= 8'h00;
            if (m_age == 0) begin
                w = -1;
                for (int k = 0; k < 8; k++) begin
                    if (w < 0 && bus.req[(m_ptr + k) % 8] === 1'b1) w = (m_ptr + k) % 8;
                end
                if (w >= 0) begin
                    m_win <= w;
                    m_age <= 1;
                end
            end else if (m_age == 1) begin
                m_data  <= data_tab[m_win];
                m_src   <= 3'(m_win);
                m_valid <= 1'b1;
                m_gnt   <= 8'(1) << m_win;
                m_ptr   <= (m_win + 1) % 8;
                m_age   <= 2;
            end else if (bus.out_ready === 1'b1) begin
                m_valid <= 1'b0;
                m_age   <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            check("m_gnt",       32'(bus.gnt),       32'(m_gnt));
            check("m_mux_sel",   32'(bus.mux_sel),   (m_age == 1) ? 32'(7 - m_win) : 32'd0);
            check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("m_busy",      32'(bus.busy),      (m_age != 0) ? 32'd1 : 32'd0);
            check("m_out_data",  bus.out_data,       m_data);
            check("m_out_src",   32'(bus.out_src),   32'(m_src));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Advance until the DUT shows the mux-steering cycle (busy, nothing held yet).
    task automatic wait_sample(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.out_valid === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_sample at %0t: no steering cycle within %0d cycles", $time, budget);
        end
    endtask

    // One full transfer with out_ready high: check select, then grant, data and source.
    task automatic rr_transfer(input int w);
        wait_sample(12);
        check("rr_mux_sel", 32'(bus.mux_sel), 32'(7 - w));
        step();
        check("rr_gnt",      32'(bus.gnt),     32'(8'(1) << w));
        check("rr_out_data", bus.out_data,     data_tab[w]);
        check("rr_out_src",  32'(bus.out_src), 32'(w));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.req       = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) data_tab[i] = 32'h0;

        // Reset held for two edges with every requester asking
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_gnt",       32'(bus.gnt),       32'd0);
        check("rst_mux_sel",   32'(bus.mux_sel),   32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);

        // Single requester 0
        data_tab[0] = 32'hFFFF_FFFF;
        bus.req = 8'h01;
        rst_n   = 1'b1;
        step();
        check("single_mux_sel",   32'(bus.mux_sel),   32'h7);
        check("single_valid_lat", 32'(bus.out_valid), 32'd0);
        check("single_busy",      32'(bus.busy),      32'd1);
        step();
        check("single_out_valid", 32'(bus.out_valid), 32'd1);
        check("single_gnt",       32'(bus.gnt),       32'h01);
        check("single_out_data",  bus.out_data,       32'hFFFF_FFFF);
        check("single_out_src",   32'(bus.out_src),   32'd0);
        bus.req = 8'h00;
        step();
        check("single_gnt_pulse", 32'(bus.gnt),       32'h00);
        check("single_accepted",  32'(bus.out_valid), 32'd0);

        // Round robin from a fresh pointer: 0,1,...,7,0
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 8; i++) data_tab[i] = 32'h1000_0000 + 32'(i);
        rst_n   = 1'b1;
        bus.req = 8'hFF;
        for (int t = 0; t < 9; t++) rr_transfer(t % 8);

        // Backpressure on requester 3
        data_tab[3] = 32'h1234_5678;
        rr_transfer(1);
        rr_transfer(2);
        wait_sample(12);
        check("bp_mux_sel", 32'(bus.mux_sel), 32'h4);
        bus.out_ready = 1'b0;
        step();
        check("bp_gnt",      32'(bus.gnt),     32'h08);
        check("bp_out_data", bus.out_data,     32'h1234_5678);
        check("bp_out_src",  32'(bus.out_src), 32'd3);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_data",  bus.out_data,       32'h1234_5678);
            check("bp_hold_gnt",   32'(bus.gnt),       32'h00);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
        step();
        check("bp_next_sel", 32'(bus.mux_sel), 32'h3);
        step();
        check("bp_next_gnt", 32'(bus.gnt), 32'h10);

        // Wrap past 7 with only requesters 0 and 7 asking
        rr_transfer(5);
        rr_transfer(6);
        rr_transfer(7);
        bus.req = 8'h81;
        wait_sample(12);
        check("wrap_sel0", 32'(bus.mux_sel), 32'h7);
        step();
        check("wrap_gnt0", 32'(bus.gnt), 32'h01);
        wait_sample(12);
        check("wrap_sel7", 32'(bus.mux_sel), 32'h0);
        step();
        check("wrap_gnt7", 32'(bus.gnt), 32'h80);

        // Requester 4 drops req during the steering cycle: word still captured
        bus.req = 8'h10;
        wait_sample(12);
        check("drop_sel", 32'(bus.mux_sel), 32'h3);
        bus.req = 8'h00;
        step();
        check("drop_gnt",  32'(bus.gnt),  32'h10);
        check("drop_data", bus.out_data,  32'h1000_0004);

        // Reset during the steering cycle: no grant issued
        bus.req = 8'h01;
        wait_sample(12);
        check("rsamp_sel", 32'(bus.mux_sel), 32'h7);
        rst_n   = 1'b0;
        bus.req = 8'h00;
        step();
        check("rsamp_gnt",   32'(bus.gnt),       32'h00);
        check("rsamp_valid", 32'(bus.out_valid), 32'd0);
        check("rsamp_busy",  32'(bus.busy),      32'd0);
        check("rsamp_sel0",  32'(bus.mux_sel),   32'h0);
        rst_n = 1'b1;

        // Reset mid-HOLD with the pointer at 2; afterwards req=06 must go to requester 1
        bus.req       = 8'h02;
        bus.out_ready = 1'b0;
        wait_sample(12);
        check("rhold_sel", 32'(bus.mux_sel), 32'h6);
        bus.req = 8'h00;
        step();
        check("rhold_gnt", 32'(bus.gnt), 32'h02);
        step();
        check("rhold_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("rhold_valid_drop", 32'(bus.out_valid), 32'd0);
        check("rhold_data_clr",   bus.out_data,       32'd0);
        check("rhold_busy",       32'(bus.busy),      32'd0);
        rst_n         = 1'b1;
        bus.req       = 8'h06;
        bus.out_ready = 1'b1;
        wait_sample(12);
        check("rhold_ptr_sel", 32'(bus.mux_sel), 32'h6);
        step();
        check("rhold_ptr_gnt", 32'(bus.gnt),     32'h02);
        check("rhold_ptr_src", 32'(bus.out_src), 32'd1);
        bus.req = 8'h00;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
